// File: rtl/cdt_pkg.sv
// rtl/cdt_pkg.sv - shared types and constants for the cycle length monitor
// Purpose: the lock FSM state encoding, the error-counter saturation value
// and the run-counter width, shared by the monitor and its sub-module.
package cdt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;
  localparam int          RUN_W       = 4;

endpackage

// File: rtl/cycle_length_monitor_if.sv
// rtl/cycle_length_monitor_if.sv - sample bus from the upstream cycle measurer
// Purpose: carries the START strobe and the measured length.
// Signals:
//   in_start  - START strobe, same signal the upstream measurer receives
//   in_length - measured cycle length, valid from the cycle after in_start
// Modports: master drives the bus (measurer side), slave observes it (monitor).
interface cycle_length_monitor_if;

  logic       in_start;
  logic [7:0] in_length;

  modport master (output in_start, output in_length);
  modport slave  (input  in_start, input  in_length);

endinterface

// File: rtl/run_counter.sv
// rtl/run_counter.sv - saturating-free 4-bit run counter with threshold detect
// Purpose: counts consecutive qualifying samples; hit flags that the current
// increment brings the count to THRESH.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   inc        - count one more qualifying sample this cycle
//   clr        - clear the run (takes priority over inc)
//   hit        - inc in this cycle reaches THRESH
module run_counter
  import cdt_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [RUN_W-1:0] THR = RUN_W'(THRESH);

  logic [RUN_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the FSM can change state on the very sample that completes the run.
  assign hit = inc && ((cnt + 1'b1) == THR);

endmodule

// File: rtl/cycle_length_monitor.sv
// rtl/cycle_length_monitor.sv - lock/unlock monitor for measured cycle lengths
// Purpose: samples the upstream length one cycle after START, classifies it
// against [cfg_min, cfg_max] and runs an IDLE/ACQUIRE/LOCKED/LOST lock FSM.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   smp           - sample bus (in_start, in_length), slave side
//   cfg_min/max   - inclusive good window; min > max makes every sample bad
//   out_locked    - high while LOCKED
//   out_err_pulse - one-cycle pulse per bad sample (not in IDLE)
//   out_err_cnt   - saturating count of bad samples
//   out_last_len  - most recent sampled length
//   out_missing   - sticky: a sample read 8'hFF
module cycle_length_monitor
  import cdt_pkg::*;
#(
  parameter int LOCK_N   = 4,
  parameter int UNLOCK_N = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cycle_length_monitor_if.slave   smp,
  input  logic [7:0]              cfg_min,
  input  logic [7:0]              cfg_max,
  output logic                    out_locked,
  output logic                    out_err_pulse,
  output logic [15:0]             out_err_cnt,
  output logic [7:0]              out_last_len,
  output logic                    out_missing
);

  state_t state_q, state_d;
  logic   strobe_q;
  logic   in_window, good, bad, active;
  logic   good_inc, good_clr, good_hit;
  logic   bad_inc, bad_clr, bad_hit;

  // The measured length becomes valid the cycle after START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= smp.in_start;
    end
  end

  // 8'hFF is the measurer's saturated value (START missing): never good.
  assign in_window = (smp.in_length >= cfg_min) && (smp.in_length <= cfg_max) &&
                     (smp.in_length != 8'hFF);
  // The first sample after reset is unaligned and is not classified.
  assign active    = strobe_q && (state_q != ST_IDLE);
  assign good      = active && in_window;
  assign bad       = active && !in_window;

  run_counter #(.THRESH(LOCK_N)) u_good_run (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (good_inc),
    .clr   (good_clr),
    .hit   (good_hit)
  );

  run_counter #(.THRESH(UNLOCK_N)) u_bad_run (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bad_inc),
    .clr   (bad_clr),
    .hit   (bad_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    good_inc = 1'b0;
    good_clr = 1'b0;
    bad_inc  = 1'b0;
    bad_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        good_clr = 1'b1;
        bad_clr  = 1'b1;
        if (strobe_q) state_d = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        bad_clr  = 1'b1;
        good_inc = good;
        if (bad) good_clr = 1'b1;
        if (good_hit) begin
          good_clr = 1'b1;
          state_d  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        good_clr = 1'b1;
        bad_inc  = bad;
        if (good) bad_clr = 1'b1;
        if (bad_hit) begin
          bad_clr = 1'b1;
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        good_clr = 1'b1;
        bad_clr  = 1'b1;
        state_d  = ST_ACQUIRE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All outputs are registered off the same edge, so a sample's full
  // effect (length, pulse, count, lock) is visible together one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_locked    <= 1'b0;
      out_err_pulse <= 1'b0;
      out_err_cnt   <= '0;
      out_last_len  <= '0;
      out_missing   <= 1'b0;
    end else begin
      out_locked    <= (state_d == ST_LOCKED);
      out_err_pulse <= bad;
      if (bad && (out_err_cnt != ERR_CNT_MAX)) out_err_cnt <= out_err_cnt + 16'd1;
      if (strobe_q) out_last_len <= smp.in_length;
      if (active && (smp.in_length == 8'hFF)) out_missing <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cycle_length_monitor.sv
// tb/tb_cycle_length_monitor.sv - scoreboard bench for cycle_length_monitor
module tb_cycle_length_monitor;

  typedef struct packed {
    logic [7:0]  len;
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    logic        missing;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_min, cfg_max;
  logic        out_locked, out_err_pulse, out_missing;
  logic [15:0] out_err_cnt;
  logic [7:0]  out_last_len;

  cycle_length_monitor_if bus ();

  cycle_length_monitor #(.LOCK_N(4), .UNLOCK_N(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .smp           (bus),
    .cfg_min       (cfg_min),
    .cfg_max       (cfg_max),
    .out_locked    (out_locked),
    .out_err_pulse (out_err_pulse),
    .out_err_cnt   (out_err_cnt),
    .out_last_len  (out_last_len),
    .out_missing   (out_missing)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  exp_t batch[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [1:0] pipe;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Bench-side timing of when a strobe's result is due, from what was driven.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= 2'b00;
    else        pipe <= {pipe[0], bus.in_start};
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pipe[1]) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sample: output due but scoreboard empty");
        end else begin
          e = sb_q.pop_front();
          check("sample {len,locked,pulse,cnt,missing}",
                {5'd0, out_last_len, out_locked, out_err_pulse, out_err_cnt, out_missing}, 32'(e));
        end
      end else begin
        check("idle err_pulse", 32'(out_err_pulse), 32'd0);
      end
    end
  end

  task automatic add(input logic [7:0] len, input logic locked, input logic pulse,
                     input logic [15:0] cnt, input logic missing);
    exp_t e;
    e.len = len; e.locked = locked; e.pulse = pulse; e.cnt = cnt; e.missing = missing;
    batch.push_back(e);
  endtask

  // Back-to-back strobes: each cycle carries a new START plus the previous length.
  task automatic send_batch();
    for (int i = 0; i < batch.size(); i++) begin
      bus.in_start = 1'b1;
      if (i > 0) bus.in_length = batch[i-1].len;
      sb_q.push_back(batch[i]);
      @(posedge clk); #1;
    end
    bus.in_start  = 1'b0;
    bus.in_length = batch[batch.size()-1].len;
    @(posedge clk); #1;
    batch.delete();
  endtask

  task automatic one(input logic [7:0] len, input logic locked, input logic pulse,
                     input logic [15:0] cnt, input logic missing);
    add(len, locked, pulse, cnt, missing);
    send_batch();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, " locked"},   32'(out_locked),    32'd0);
    check({tag, " pulse"},    32'(out_err_pulse), 32'd0);
    check({tag, " err_cnt"},  32'(out_err_cnt),   32'd0);
    check({tag, " last_len"}, 32'(out_last_len),  32'd0);
    check({tag, " missing"},  32'(out_missing),   32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_start  = 1'b0;
    bus.in_length = 8'd0;
    cfg_min = 8'd15;
    cfg_max = 8'd25;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Acquire: first sample ignored, lock on the fourth good sample.
    one(8'd10, 0, 0, 16'd0, 0);
    one(8'd20, 0, 0, 16'd0, 0);
    one(8'd20, 0, 0, 16'd0, 0);
    one(8'd20, 0, 0, 16'd0, 0);
    one(8'd20, 1, 0, 16'd0, 0);

    // Locked: an isolated bad sample keeps lock, the consecutive pair loses it.
    one(8'd30, 1, 1, 16'd1, 0);
    one(8'd20, 1, 0, 16'd1, 0);
    one(8'd30, 1, 1, 16'd2, 0);
    one(8'd30, 0, 1, 16'd3, 0);

    // Missing START while acquiring; flag stays set over later good samples.
    one(8'hFF, 0, 1, 16'd4, 1);
    one(8'd20, 0, 0, 16'd4, 1);
    one(8'd20, 0, 0, 16'd4, 1);
    add(8'd20, 0, 0, 16'd4, 1);
    add(8'd20, 1, 0, 16'd4, 1);
    send_batch();

    // Inverted window: everything bad, lock lost and never regained.
    cfg_min = 8'd40;
    cfg_max = 8'd30;
    one(8'd35, 1, 1, 16'd5, 1);
    one(8'd35, 0, 1, 16'd6, 1);
    one(8'd20, 0, 1, 16'd7, 1);
    one(8'd35, 0, 1, 16'd8, 1);
    one(8'd0,  0, 1, 16'd9, 1);
    one(8'd255, 0, 1, 16'd10, 1);

    // Error counter saturation.
    for (int i = 1; i <= 65540; i++) begin
      int v;
      v = 10 + i;
      add(8'd50, 0, 1, (v > 65535) ? 16'hFFFF : 16'(v), 1);
    end
    send_batch();
    check("saturated err_cnt", 32'(out_err_cnt), 32'h0000FFFF);

    // Relock, then asynchronous reset between edges.
    cfg_min = 8'd15;
    cfg_max = 8'd25;
    add(8'd20, 0, 0, 16'hFFFF, 1);
    add(8'd20, 0, 0, 16'hFFFF, 1);
    add(8'd20, 0, 0, 16'hFFFF, 1);
    add(8'd20, 1, 0, 16'hFFFF, 1);
    send_batch();
    check("relocked before reset", 32'(out_locked), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First sample after reset ignored again.
    one(8'd20, 0, 0, 16'd0, 0);
    one(8'd30, 0, 1, 16'd1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
